// File: rtl/mm_pkg.sv
// Shared constants and state encoding for the 3x3 MAC array.
// Build option MAC_PIPE_EN adds a product register stage in every mac_cell.
package mm_pkg;

    localparam int DIM    = 3;
    localparam int DATA_W = 4;
    localparam int ACC_W  = 10;
    localparam int IDX_W  = 4;

    typedef logic [2:0] state_t;

    localparam state_t IDLE  = 3'd0;
    localparam state_t ACCUM = 3'd1;
    localparam state_t DRAIN = 3'd2;
    localparam state_t DONE  = 3'd3;
    localparam state_t WAIT  = 3'd4;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIM * DIM - 1);

    function automatic logic [ACC_W-1:0] widen(
        input logic [2*DATA_W-1:0] p
    );
        return ACC_W'(p);
    endfunction

endpackage

// File: rtl/mac_cell.sv
// One multiply-accumulate element of the 3x3 array.
// With MAC_PIPE_EN the product is registered before it is accumulated.
module mac_cell
    import mm_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              en,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [ACC_W-1:0]  acc
);

    logic [2*DATA_W-1:0] prod;

    assign prod = a * b;

`ifdef MAC_PIPE_EN
    logic [2*DATA_W-1:0] p_q;
    logic                p_vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q   <= '0;
            p_vld <= 1'b0;
        end else if (clr) begin
            p_q   <= '0;
            p_vld <= 1'b0;
        end else begin
            p_q   <= prod;
            p_vld <= en;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (p_vld) begin
            acc <= acc + widen(p_q);
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + widen(prod);
        end
    end
`endif

endmodule

// File: rtl/mac_array_3x3.sv
// 3x3 outer-product MAC array with serial row-major result drain.
// Build option MAC_PIPE_EN adds one product pipeline stage (one extra ACCUM cycle).
module mac_array_3x3
    import mm_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld_mac,
    input  logic              clear_mac,
    input  logic [1:0]        k_len,
    input  logic [DATA_W-1:0] w1,
    input  logic [DATA_W-1:0] w2,
    input  logic [DATA_W-1:0] w3,
    input  logic [DATA_W-1:0] x1,
    input  logic [DATA_W-1:0] x2,
    input  logic [DATA_W-1:0] x3,
    output logic [ACC_W-1:0]  out_data,
    output logic [IDX_W-1:0]  out_idx,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    state_t           state;
    logic [1:0]       k_reg;
    logic [1:0]       step;
    logic [IDX_W-1:0] idx;
    logic             last_step;
    logic             acc_en;
    logic             xfer;

    logic [DATA_W-1:0] w_v [DIM];
    logic [DATA_W-1:0] x_v [DIM];
    logic [ACC_W-1:0]  acc [DIM*DIM];

    assign w_v[0] = w1;
    assign w_v[1] = w2;
    assign w_v[2] = w3;
    assign x_v[0] = x1;
    assign x_v[1] = x2;
    assign x_v[2] = x3;

    for (genvar gi = 0; gi < DIM; gi++) begin : g_row
        for (genvar gj = 0; gj < DIM; gj++) begin : g_col
            mac_cell u_cell (
                .clk   (clk),
                .rst_n (rst_n),
                .clr   (clear_mac),
                .en    (acc_en),
                .a     (w_v[gi]),
                .b     (x_v[gj]),
                .acc   (acc[gi*DIM+gj])
            );
        end
    end

    // The pipelined build spends one extra ACCUM cycle flushing products.
`ifdef MAC_PIPE_EN
    assign last_step = (step == k_reg);
    assign acc_en    = (state == ACCUM) && !last_step;
`else
    assign last_step = (step == k_reg - 2'd1);
    assign acc_en    = (state == ACCUM);
`endif

    assign xfer = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            k_reg <= '0;
            step  <= '0;
            idx   <= '0;
        end else if (clear_mac) begin
            state <= IDLE;
            k_reg <= '0;
            step  <= '0;
            idx   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (ld_mac) begin
                        k_reg <= k_len;
                        step  <= '0;
                        state <= (k_len == 2'd0) ? DRAIN : ACCUM;
                    end
                end
                ACCUM: begin
                    if (last_step) begin
                        step  <= '0;
                        state <= DRAIN;
                    end else begin
                        step <= step + 2'd1;
                    end
                end
                DRAIN: begin
                    if (xfer) begin
                        if (idx == LAST_IDX) begin
                            idx   <= '0;
                            state <= DONE;
                        end else begin
                            idx <= idx + 4'd1;
                        end
                    end
                end
                DONE: begin
                    state <= WAIT;
                end
                WAIT: begin
                    state <= WAIT;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign out_valid = (state == DRAIN);
    assign out_last  = out_valid && (idx == LAST_IDX);
    assign out_idx   = out_valid ? idx : '0;
    assign out_data  = out_valid ? acc[idx] : '0;
    assign done      = (state == DONE);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_mac_array_3x3.sv
// Directed, table-driven bench for mac_array_3x3.
// Expected matrices are hand-computed constants in the job table.
module tb_mac_array_3x3;
    import mm_pkg::*;

`ifdef MAC_PIPE_EN
    localparam int PIPE = 1;
`else
    localparam int PIPE = 0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             ld_mac = 1'b0;
    logic             clear_mac = 1'b1;
    logic [1:0]       k_len = '0;
    logic [3:0]       w1 = '0, w2 = '0, w3 = '0;
    logic [3:0]       x1 = '0, x2 = '0, x3 = '0;
    logic             out_ready = 1'b0;
    logic [ACC_W-1:0] out_data;
    logic [IDX_W-1:0] out_idx;
    logic             out_valid;
    logic             out_last;
    logic             busy;
    logic             done;

    mac_array_3x3 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ld_mac    (ld_mac),
        .clear_mac (clear_mac),
        .k_len     (k_len),
        .w1        (w1),
        .w2        (w2),
        .w3        (w3),
        .x1        (x1),
        .x2        (x2),
        .x3        (x3),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]             k;
        logic [2:0][2:0][3:0]   w;
        logic [2:0][2:0][3:0]   x;
        logic [8:0][ACC_W-1:0]  c;
    } job_t;

    job_t jobs [4];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic zero_in();
        w1 = '0; w2 = '0; w3 = '0;
        x1 = '0; x2 = '0; x3 = '0;
    endtask

    task automatic drive_step(input int j, input int s);
        if (s < 3) begin
            w1 = jobs[j].w[s][0];
            w2 = jobs[j].w[s][1];
            w3 = jobs[j].w[s][2];
            x1 = jobs[j].x[s][0];
            x2 = jobs[j].x[s][1];
            x3 = jobs[j].x[s][2];
        end else begin
            zero_in();
        end
    endtask

    task automatic run_job(input int j, input int rmode, input int stop_at);
        int lat;
        int e;
        int cyc;
        @(negedge clk);
        ld_mac = 1'b1;
        clear_mac = 1'b0;
        k_len = jobs[j].k;
        out_ready = 1'b0;
        zero_in();
        @(posedge clk);
        #1;
        lat = 1;
        k_len = 2'd3;
        while (!out_valid && lat < 20) begin
            drive_step(j, lat - 1);
            @(posedge clk);
            #1;
            lat++;
        end
        zero_in();
        chk("latency", lat, int'(jobs[j].k) + 1 + PIPE);
        e = 0;
        cyc = 0;
        while (e < stop_at && cyc < 60) begin
            out_ready = (rmode == 0) ? 1'b1 : (cyc % 3 == 0);
            chk("out_valid", int'(out_valid), 1);
            chk("out_idx", int'(out_idx), e);
            chk("out_data", int'(out_data), int'(jobs[j].c[e]));
            chk("out_last", int'(out_last), (e == 8) ? 1 : 0);
            if (out_valid && out_ready) e++;
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("beats", e, stop_at);
        if (stop_at == 9) begin
            out_ready = 1'b0;
            chk("done_pulse", int'(done), 1);
            chk("valid_in_done", int'(out_valid), 0);
            @(posedge clk);
            #1;
            chk("done_once", int'(done), 0);
            chk("busy_wait", int'(busy), 1);
            @(negedge clk);
            ld_mac = 1'b0;
            clear_mac = 1'b1;
            @(posedge clk);
            #1;
            chk("busy_idle", int'(busy), 0);
            chk("valid_idle", int'(out_valid), 0);
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) jobs[i] = '0;
        jobs[0].k    = 2'd3;
        jobs[0].w[0] = {4'd7, 4'd4, 4'd1};
        jobs[0].w[1] = {4'd8, 4'd5, 4'd2};
        jobs[0].w[2] = {4'd9, 4'd6, 4'd3};
        jobs[0].x[0] = {4'd0, 4'd0, 4'd1};
        jobs[0].x[1] = {4'd0, 4'd1, 4'd0};
        jobs[0].x[2] = {4'd1, 4'd0, 4'd0};
        jobs[0].c    = {10'd9, 10'd8, 10'd7, 10'd6, 10'd5,
                        10'd4, 10'd3, 10'd2, 10'd1};
        jobs[1].k    = 2'd3;
        jobs[1].w    = {9{4'd15}};
        jobs[1].x    = {9{4'd15}};
        jobs[1].c    = {9{10'd675}};
        jobs[2].k    = 2'd2;
        jobs[2].w[0] = {4'd1, 4'd0, 4'd2};
        jobs[2].w[1] = {4'd0, 4'd3, 4'd1};
        jobs[2].w[2] = {3{4'd5}};
        jobs[2].x[0] = {4'd0, 4'd2, 4'd1};
        jobs[2].x[1] = {4'd4, 4'd1, 4'd0};
        jobs[2].x[2] = {3{4'd5}};
        jobs[2].c    = {10'd0, 10'd2, 10'd1, 10'd12, 10'd3,
                        10'd0, 10'd4, 10'd5, 10'd2};
        jobs[3].k    = 2'd0;

        #12;
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_last", int'(out_last), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_data", int'(out_data), 0);
        chk("rst_idx", int'(out_idx), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_job(0, 0, 9);
        run_job(1, 0, 9);
        run_job(1, 1, 9);
        run_job(2, 0, 9);
        run_job(3, 0, 9);

        @(negedge clk);
        ld_mac = 1'b1;
        clear_mac = 1'b0;
        k_len = 2'd3;
        @(posedge clk);
        #1;
        drive_step(1, 0);
        @(posedge clk);
        #1;
        drive_step(1, 1);
        ld_mac = 1'b0;
        clear_mac = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            chk("abort_valid", int'(out_valid), 0);
        end
        chk("abort_busy", int'(busy), 0);
        zero_in();
        run_job(0, 0, 9);

        run_job(1, 0, 4);
        chk("pre_rst_idx", int'(out_idx), 4);
        rst_n = 1'b0;
        #1;
        chk("arst_valid", int'(out_valid), 0);
        chk("arst_last", int'(out_last), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_done", int'(done), 0);
        chk("arst_data", int'(out_data), 0);
        chk("arst_idx", int'(out_idx), 0);
        @(negedge clk);
        ld_mac = 1'b0;
        clear_mac = 1'b1;
        out_ready = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        run_job(0, 0, 9);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mac_array_3x3.md
Name: mac_array_3x3

Overview:
- Consumes the unload stream of the operand memory bank, which supplies, per cycle, one column of W (w1..w3) and one row of X (x1..x3).
- Accumulates the 3x3 product C = W·X as a sum of outer products over K steps.
- Drains the nine results serially, row-major, over a valid/ready handshake to the result writer.
- Sits directly downstream of the memory bank and upstream of the output/result path.

Parameters:
- DIM, 3, matrix dimension (fixed 3; elaborated loops use it)
- DATA_W, 4, unsigned operand width
- ACC_W, 10, accumulator width; 3·15·15 = 675 fits, so no overflow is possible at defaults

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- ld_mac  in  1  operand stream active (from memory bank)
- clear_mac  in  1  synchronous clear/abort (from memory bank; complement of ld_mac)
- k_len  in  2  inner dimension K (= W column count), 0..3
- w1, w2, w3  in  DATA_W  current W column elements, rows 0..2
- x1, x2, x3  in  DATA_W  current X row elements, columns 0..2
- out_data  out  ACC_W  result element C[i][j]
- out_idx  out  4  linear index i·3+j, 0..8
- out_valid  out  1  out_data/out_idx valid
- out_ready  in  1  downstream accepts when high with out_valid
- out_last  out  1  high with out_idx==8
- busy  out  1  state is not IDLE
- done  out  1  one-cycle pulse after the last beat is accepted

Behaviour:
- Reset (rst_n low, async):
  - state=IDLE; all 9 accumulators, step counter, and drain index = 0.
  - Outputs out_valid, out_last, busy, done, out_data, out_idx all 0.
- Priority, every cycle: rst_n > clear_mac > state logic.
- clear_mac high (any state): next cycle all accumulators=0, counters=0, state=IDLE, out_valid=0. Any drain in progress is abandoned and done is not pulsed.
- IDLE:
  - On ld_mac=1 and clear_mac=0, capture k_len into k_reg.
  - If k_reg≠0, go to ACCUM; the same cycle is step 0, and accumulation happens in that cycle.
  - If k_len==0, go to DRAIN with all accumulators 0.
- ACCUM:
  - Each cycle: acc[i][j] += w(i+1)·x(j+1). Products are DATA_W×DATA_W → 2·DATA_W bits, zero-extended to ACC_W.
  - step increments 0..k_reg-1. After the step k_reg-1 update, go to DRAIN.
  - Inputs after K steps are ignored; the bank drives zeros then.
  - k_len changes after capture are ignored.
- DRAIN:
  - out_valid=1, out_data=acc[idx/3][idx%3], out_idx=idx, out_last=(idx==8).
  - Beat transfers when out_valid&&out_ready; idx then increments.
  - With out_ready low, out_data, out_idx, and out_last hold stable.
  - Transfer at idx==8 → go to DONE.
- DONE:
  - done=1 for exactly this one cycle; out_valid=0.
  - Accumulators keep their values; then go to WAIT.
- WAIT: hold until clear_mac=1 (ld_mac drops), then go to IDLE. A new job requires an ld_mac low→high sequence.
- Latency: first out_valid appears K+1 cycles after the IDLE→ACCUM edge (K=3 → 4).
- Abort: ld_mac falling during ACCUM asserts clear_mac, so the job is aborted with no output.

Optional Feature:
- Macro MAC_PIPE_EN.
- Defined:
  - The nine products are registered, adding one pipeline stage.
  - The accumulator adds the registered product one cycle later.
  - ACCUM lasts K+1 cycles; the final cycle only flushes the pipe.
  - First out_valid appears K+2 cycles after entry.
  - clear_mac also zeroes the product registers.
- Undefined: combinational multiply-accumulate as described above.
- Results are identical in both builds.

Decomposition:
- Package mm_pkg:
  - DIM, DATA_W, ACC_W constants.
  - state enum {IDLE, ACCUM, DRAIN, DONE, WAIT}.
  - Index width constant (4).
- Sub-module mac_cell, instantiated DIM×DIM times. Contents: multiplier, optional product register (MAC_PIPE_EN), ACC_W accumulator. Inputs: clk, rst_n, clr, en, a, b. Output: acc.
- Top-level contents: FSM, step/drain counters, output mux.

Test Plan:
- Identity: W=[[1,2,3],[4,5,6],[7,8,9]], X=I, k_len=3. Columns (1,4,7),(2,5,8),(3,6,9) with rows e0,e1,e2. → stream 1..9, idx 0..8, out_last on idx 8, done pulses once.
- Max values: all operands 15, k_len=3, out_ready=1. → nine beats of 675, no wrap.
- Backpressure: same job as max values, out_ready toggling 1,0,0,1,... → no beat lost or duplicated; out_data/out_idx stable while stalled; exactly 9 transfers.
- Short K: k_len=2, w columns (2,0,1),(1,3,0), x rows (1,2,0),(0,1,4). → C=[[2,5,4],[0,3,12],[1,2,0]]; inputs after step 1 ignored.
- Abort: drop ld_mac during ACCUM step 1, then restart with the identity job. → no out_valid during the abort; restart yields exactly 1..9 with no residue.
- Reset: rst_n low during DRAIN at idx 4. → all outputs 0 immediately; busy=0; next job is correct.
